// File: rtl/md_issue_ctrl.sv
// HI/LO multiply/divide issue, latency tracking, stall and abort control.
// Define MD_MADD_EN to decode SPECIAL2 madd as a multiply-class op.
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_e,
    input  logic        int_req,
    output logic        start,
    output logic [2:0]  md_op,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        abort
);

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MT,
        CLS_MF
    } cls_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    function automatic cls_t decode_cls(input logic [5:0] op,
                                        input logic [5:0] fn);
        cls_t c;
        c = CLS_NONE;
        if (op == 6'b000000) begin
            case (fn)
                6'b011000, 6'b011001: c = CLS_MUL;
                6'b011010, 6'b011011: c = CLS_DIV;
                6'b010001, 6'b010011: c = CLS_MT;
                6'b010000, 6'b010010: c = CLS_MF;
                default:              c = CLS_NONE;
            endcase
        end
`ifdef MD_MADD_EN
        if (op == 6'b011100 && fn == 6'b000000) begin
            c = CLS_MUL;
        end
`endif
        return c;
    endfunction

    function automatic logic [2:0] decode_op(input logic [5:0] op,
                                             input logic [5:0] fn);
        logic [2:0] r;
        r = 3'b111;
        if (op == 6'b000000) begin
            case (fn)
                6'b011001: r = 3'b000;
                6'b011000: r = 3'b001;
                6'b011011: r = 3'b010;
                6'b011010: r = 3'b011;
                6'b010001: r = 3'b100;
                6'b010011: r = 3'b101;
                default:   r = 3'b111;
            endcase
        end
`ifdef MD_MADD_EN
        if (op == 6'b011100 && fn == 6'b000000) begin
            r = 3'b110;
        end
`endif
        return r;
    endfunction

    state_t     state;
    logic [3:0] cnt;
    cls_t       cls_d;
    cls_t       cls_e;
    logic       issue_e;
    logic       hilo_d;
    logic       hilo_e;
    logic       unused_instr_bits;

    // Only the opcode and funct fields take part in decode.
    assign unused_instr_bits = ^{instr_d[25:6], instr_e[25:6]};

    assign cls_d   = decode_cls(instr_d[31:26], instr_d[5:0]);
    assign cls_e   = decode_cls(instr_e[31:26], instr_e[5:0]);
    assign issue_e = (cls_e == CLS_MUL) || (cls_e == CLS_DIV);
    assign hilo_d  = (cls_d != CLS_NONE);
    assign hilo_e  = (cls_e != CLS_NONE);

    assign md_op = decode_op(instr_e[31:26], instr_e[5:0]);
    assign busy  = (cnt != 4'd0);
    assign start = issue_e && !busy && !int_req;
    assign stall = hilo_d && (busy || start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= (cls_e == CLS_DIV) ? DIV_N : MULT_N;
                    end
                end
                RUN: begin
                    // A kill wins over a completion landing on the same edge.
                    if (int_req) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        abort <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    hilo_in_e_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(busy && hilo_e)
    );
`endif

endmodule
